// File: rtl/clock_rate_monitor_pkg.sv
// Shared definitions for the clock rate monitor.
// Holds the FSM state encoding and the default counter widths used by the interface, the top
// and the testbench.
package clock_rate_monitor_pkg;

   localparam int unsigned DefWinW = 16;  // window length width, core_clk cycles
   localparam int unsigned DefCntW = 16;  // edge counter / result width

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StMeasure = 2'd1,
      StReport  = 2'd2
   } crm_state_e;

endpackage

// File: rtl/clock_rate_monitor_if.sv
// Request/result bundle of the clock rate monitor.
// Signals:
//   start    - one-cycle request to begin a measurement
//   window   - measurement length in core_clk cycles, sampled on an accepted start
//   busy     - measurement in progress
//   done     - one-cycle pulse when a new result is valid
//   count    - mon_clk rising edges counted in the last window
//   overflow - count saturated during the last window
//   stuck    - last window saw no edges
// Modports: master drives requests (firmware/SPI side), slave is the monitor.
interface clock_rate_monitor_if
   import clock_rate_monitor_pkg::*;
#(
   parameter int unsigned WinW = DefWinW,
   parameter int unsigned CntW = DefCntW
);

   logic            start;
   logic [WinW-1:0] window;
   logic            busy;
   logic            done;
   logic [CntW-1:0] count;
   logic            overflow;
   logic            stuck;

   modport master (
      output start,
      output window,
      input  busy,
      input  done,
      input  count,
      input  overflow,
      input  stuck
   );

   modport slave (
      input  start,
      input  window,
      output busy,
      output done,
      output count,
      output overflow,
      output stuck
   );

endinterface

// File: rtl/clock_rate_monitor_mon_sync_edge.sv
// Brings an asynchronous clock into the core_clk domain and flags its rising edges.
// Two-flop synchronizer followed by an edge register; the flops run continuously so the edge
// flag is already meaningful when a measurement starts.
// Ports:
//   clk_i   - core clock
//   rst_i   - synchronous active-high reset
//   async_i - asynchronous clock being observed
//   rise_o  - one-cycle flag per rising edge of async_i (2-3 cycles of latency)
module clock_rate_monitor_mon_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic edge_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
         edge_q  <= sync2_q;
      end
   end

   assign rise_o = sync2_q & ~edge_q;

endmodule

// File: rtl/clock_rate_monitor.sv
// Measures the frequency of an asynchronous clock by counting its rising edges over a
// programmable window of core_clk cycles. Used to confirm PLL/divider settings before core_clk
// is switched over.
// Ports:
//   core_clk - single clock for every flop in the block
//   reset    - synchronous active-high reset
//   mon_clk  - asynchronous clock under measurement
//   bus      - request/result bundle (slave side), see clock_rate_monitor_if
module clock_rate_monitor
   import clock_rate_monitor_pkg::*;
#(
   parameter int unsigned WinW = DefWinW,
   parameter int unsigned CntW = DefCntW
) (
   input  logic                 core_clk,
   input  logic                 reset,
   input  logic                 mon_clk,
   clock_rate_monitor_if.slave  bus
);

   crm_state_e      state_q, state_d;
   logic [WinW-1:0] win_cnt_q, win_cnt_d;
   logic [CntW-1:0] edge_cnt_q, edge_cnt_d;
   logic            sat_q, sat_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [CntW-1:0] count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            stuck_q, stuck_d;
   logic            rise;

   clock_rate_monitor_mon_sync_edge u_mon_sync_edge (
      .clk_i   (core_clk),
      .rst_i   (reset),
      .async_i (mon_clk),
      .rise_o  (rise)
   );

   // State register and datapath flops.
   always_ff @(posedge core_clk) begin
      if (reset) begin
         state_q    <= StIdle;
         win_cnt_q  <= '0;
         edge_cnt_q <= '0;
         sat_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         stuck_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_cnt_q  <= win_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         sat_q      <= sat_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         stuck_q    <= stuck_d;
      end
   end

   // Next-state logic. A zero-length window is silently rejected; start is not looked at
   // outside IDLE, so a request during a measurement is dropped.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start && (bus.window != '0)) begin
               state_d = StMeasure;
            end
         end
         StMeasure: begin
            // win_cnt == 1 marks the last of exactly `window` sample cycles.
            if (win_cnt_q == WinW'(1)) begin
               state_d = StReport;
            end
         end
         StReport: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Counters and output registers.
   always_comb begin
      win_cnt_d  = win_cnt_q;
      edge_cnt_d = edge_cnt_q;
      sat_d      = sat_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      stuck_d    = stuck_q;
      done_d     = 1'b0;
      // busy covers exactly the sample cycles, so it drops one cycle before done pulses.
      busy_d     = (state_d == StMeasure);

      unique case (state_q)
         StIdle: begin
            if (state_d == StMeasure) begin
               win_cnt_d  = bus.window;
               edge_cnt_d = '0;
               sat_d      = 1'b0;
            end
         end
         StMeasure: begin
            // Never underflows: the FSM leaves MEASURE when win_cnt reaches 1.
            win_cnt_d = win_cnt_q - WinW'(1);
            if (rise) begin
               if (&edge_cnt_q) begin
                  sat_d = 1'b1;
               end else begin
                  edge_cnt_d = edge_cnt_q + CntW'(1);
               end
            end
         end
         StReport: begin
            count_d    = edge_cnt_q;
            overflow_d = sat_q;
            stuck_d    = (edge_cnt_q == '0);
            done_d     = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
   assign bus.stuck    = stuck_q;

endmodule

// File: tb/tb_clock_rate_monitor.sv
// Directed testbench for clock_rate_monitor.
// Two instances: a default-width one for most scenarios and a CntW=4 one for saturation.
module tb_clock_rate_monitor;

   logic core_clk = 1'b0;
   logic reset;
   logic mon_clk;
   bit   mon_run  = 1'b1;
   int   mon_half = 40;   // core_clk period is 20, so 40 gives core_clk/4

   int n_checks = 0;
   int n_bad    = 0;

   clock_rate_monitor_if #(.WinW(16), .CntW(16)) bus_a ();
   clock_rate_monitor_if #(.WinW(16), .CntW(4))  bus_b ();

   clock_rate_monitor #(.WinW(16), .CntW(16)) u_dut_a (
      .core_clk (core_clk),
      .reset    (reset),
      .mon_clk  (mon_clk),
      .bus      (bus_a)
   );

   clock_rate_monitor #(.WinW(16), .CntW(4)) u_dut_b (
      .core_clk (core_clk),
      .reset    (reset),
      .mon_clk  (mon_clk),
      .bus      (bus_b)
   );

   always #10 core_clk = ~core_clk;

   // Monitored clock, offset so its edges never coincide with core_clk edges.
   initial begin
      mon_clk = 1'b0;
      #7;
      forever begin
         if (mon_run) begin
            #(mon_half);
            mon_clk = ~mon_clk;
         end else begin
            mon_clk = 1'b0;
            #1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic drive_start(input bit use_b, input logic s, input logic [15:0] w);
      if (use_b) begin
         bus_b.start  = s;
         bus_b.window = w;
      end else begin
         bus_a.start  = s;
         bus_a.window = w;
      end
   endtask

   // Issues one start; lat = cycles from the accepting edge until done is seen (-1 on timeout),
   // nbusy = cycles with busy high before done. poke_mid re-pulses start 4 cycles in.
   task automatic measure(input bit use_b, input logic [15:0] w, input bit poke_mid,
                          output int lat, output int nbusy);
      @(posedge core_clk); #1;
      drive_start(use_b, 1'b1, w);
      lat   = -1;
      nbusy = 0;
      for (int k = 0; k < int'(w) + 20; k++) begin
         @(posedge core_clk); #1;
         drive_start(use_b, poke_mid && (k == 4), w);
         if (use_b ? bus_b.busy : bus_a.busy) nbusy++;
         if (use_b ? bus_b.done : bus_a.done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic watch(input int n, output int nbusy, output int ndone);
      nbusy = 0;
      ndone = 0;
      repeat (n) begin
         @(posedge core_clk); #1;
         if (bus_a.busy) nbusy++;
         if (bus_a.done) ndone++;
      end
   endtask

   initial begin
      int lat;
      int nb;
      int nd;

      reset = 1'b1;
      drive_start(1'b0, 1'b0, 16'd0);
      drive_start(1'b1, 1'b0, 16'd0);
      repeat (3) @(posedge core_clk);
      #1;
      check("rst_busy", bus_a.busy, 0);
      check("rst_done", bus_a.done, 0);
      check("rst_count", bus_a.count, 0);
      check("rst_overflow", bus_a.overflow, 0);
      check("rst_stuck", bus_a.stuck, 0);
      check("rst_b_busy", bus_b.busy, 0);
      reset = 1'b0;

      // core_clk/4, window=100: about 25 edges
      repeat (5) @(posedge core_clk);
      measure(1'b0, 16'd100, 1'b0, lat, nb);
      check("div4_latency", lat, 101);
      check("div4_busy_cycles", nb, 100);
      check("div4_count_in_24_26", (bus_a.count >= 24) && (bus_a.count <= 26), 1);
      check("div4_overflow", bus_a.overflow, 0);
      check("div4_stuck", bus_a.stuck, 0);

      // mon_clk held low, window=50
      mon_run = 1'b0;
      repeat (10) @(posedge core_clk);
      measure(1'b0, 16'd50, 1'b0, lat, nb);
      check("dead_latency", lat, 51);
      check("dead_count", bus_a.count, 0);
      check("dead_stuck", bus_a.stuck, 1);
      check("dead_overflow", bus_a.overflow, 0);
      watch(20, nb, nd);
      check("dead_extra_done", nd, 0);
      check("dead_result_held", bus_a.stuck, 1);

      // CntW=4 at core_clk/2.5: ~40 edges saturate at 15
      mon_half = 25;
      mon_run  = 1'b1;
      repeat (5) @(posedge core_clk);
      measure(1'b1, 16'd100, 1'b0, lat, nb);
      check("sat_latency", lat, 101);
      check("sat_count", bus_b.count, 15);
      check("sat_overflow", bus_b.overflow, 1);
      check("sat_stuck", bus_b.stuck, 0);

      // window=0 is ignored, then window=8 runs normally
      mon_half = 40;
      @(posedge core_clk); #1;
      drive_start(1'b0, 1'b1, 16'd0);
      @(posedge core_clk); #1;
      drive_start(1'b0, 1'b0, 16'd0);
      watch(10, nb, nd);
      check("win0_busy", nb, 0);
      check("win0_done", nd, 0);
      measure(1'b0, 16'd8, 1'b0, lat, nb);
      check("win8_latency", lat, 9);
      check("win8_busy_cycles", nb, 8);
      check("win8_count_in_1_3", (bus_a.count >= 1) && (bus_a.count <= 3), 1);
      check("win8_stuck", bus_a.stuck, 0);

      // reset 10 cycles into a window=100 measurement
      @(posedge core_clk); #1;
      drive_start(1'b0, 1'b1, 16'd100);
      repeat (10) begin
         @(posedge core_clk); #1;
         drive_start(1'b0, 1'b0, 16'd100);
      end
      check("abort_busy_before", bus_a.busy, 1);
      reset = 1'b1;
      @(posedge core_clk); #1;
      reset = 1'b0;
      check("abort_busy", bus_a.busy, 0);
      check("abort_done", bus_a.done, 0);
      check("abort_count", bus_a.count, 0);
      check("abort_overflow", bus_a.overflow, 0);
      check("abort_stuck", bus_a.stuck, 0);
      watch(120, nb, nd);
      check("abort_no_done", nd, 0);
      check("abort_no_busy", nb, 0);
      measure(1'b0, 16'd20, 1'b0, lat, nb);
      check("after_abort_latency", lat, 21);

      // start re-pulsed mid-measure is ignored; back-to-back start after done accepted
      measure(1'b0, 16'd30, 1'b1, lat, nb);
      check("poke_latency", lat, 31);
      check("poke_busy_cycles", nb, 30);
      measure(1'b0, 16'd12, 1'b0, lat, nb);
      check("b2b_latency", lat, 13);

      // start together with reset: reset wins
      @(posedge core_clk); #1;
      reset = 1'b1;
      drive_start(1'b0, 1'b1, 16'd10);
      @(posedge core_clk); #1;
      reset = 1'b0;
      drive_start(1'b0, 1'b0, 16'd10);
      check("rst_start_busy", bus_a.busy, 0);
      watch(20, nb, nd);
      check("rst_start_no_done", nd, 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
